aes_mix_columns_seq: RTL and testbench
======================================

# aes_mix_columns_seq

Sequential, parametrised MixColumns engine for the full 4x4 AES state, forward (MixColumns) or inverse (InvMixColumns). It processes `ColsPerCycle` columns per clock, trading area against latency. Input and output use valid/ready handshakes. It sits between the ShiftRows and AddRoundKey stages of an area-optimised AES cipher core. An illegal operation encoding is detected and flagged.

## Interface
- `ColsPerCycle`, default 1: columns transformed per cycle; legal values 1, 2, 4; any other value is an elaboration error.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous abort; wipes state and returns to IDLE.
- `op_i`  in  `aes_pkg::ciph_op_e`  CIPH_FWD or CIPH_INV; sampled on input handshake only.
- `in_valid_i`  in  1  input state valid.
- `in_ready_o`  out  1  engine can accept a state.
- `data_i`  in  [3:0][3:0][7:0]  state, indexed [row][col].
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts result.
- `data_o`  out  [3:0][3:0][7:0]  result, indexed [row][col].
- `err_o`  out  1  latched op was neither CIPH_FWD nor CIPH_INV; valid while `out_valid_o`=1.

## Operation
- FSM states IDLE, CALC, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready_o`=1.
  - On `in_valid_i`&&`in_ready_o`: latch `data_i` into the state register, latch `op_i`, set column counter to 0, go to CALC.
- CALC:
  - `in_ready_o`=0.
  - Each cycle, columns `cnt*ColsPerCycle` .. `cnt*ColsPerCycle+ColsPerCycle-1` are replaced in place by their transform, and the counter increments.
  - Counter width is max(1, log2(4/ColsPerCycle)).
  - After the cycle that processes column 3, go to DONE.
- DONE:
  - `out_valid_o`=1.
  - `data_o` and `err_o` are held stable until `out_ready_i`=1.
  - On handshake, go to IDLE. A new input is accepted no earlier than the following cycle; there is no same-cycle turnaround.
- Column transform, with bytes a0..a3 = rows 0..3 of one column and GF(2^8) modulus x^8+x^4+x^3+x+1:
  - Forward: b0=2a0^3a1^a2^a3; b1=a0^2a1^3a2^a3; b2=a0^a1^2a2^3a3; b3=3a0^a1^a2^2a3.
  - Inverse: b0=e·a0^b·a1^d·a2^9·a3, with rows rotated the same way as forward.
  - Implement the inverse as a shared forward datapath plus a pre-multiply term, using the `aes_pkg` mul2/mul4 functions.
- Illegal op: the transform is skipped, the state register is zeroed on entry to CALC, `data_o`=0, and `err_o`=1 in DONE. Timing is unchanged.
- `clear_i`=1 in any state:
  - Next cycle: IDLE, state register=0, counter=0, `out_valid_o`=0, `err_o`=0.
  - `clear_i` has priority over any handshake in the same cycle.
- Changes on `op_i` or `data_i` outside the input handshake have no effect.

## Timing
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `data_o`=0, `err_o`=0, counter=0, FSM=IDLE.
- Latency: an input handshake at edge t gives `out_valid_o`=1 after edge t+4/`ColsPerCycle`, i.e. 4, 2 or 1 cycles.
- Throughput with `out_ready_i` tied high: one state per 4/`ColsPerCycle`+2 cycles.
- `data_o` drives the state register directly, so output is registered. `data_o` is 0 whenever FSM≠DONE.
- `in_ready_o` and `out_valid_o` are pure decodes of FSM state and have no combinational path from inputs.
- Asynchronous reset mid-CALC aborts immediately. There is no partial output.

## Test plan
- FWD, `ColsPerCycle`=1: col0=db 13 53 45, col1=f2 0a 22 5c, col2=01 01 01 01, col3=2d 26 31 4c.
  - Required: `out_valid_o` 4 cycles after accept.
  - Required output: cols 8e 4d a1 bc / 9f dc 58 9d / 01 01 01 01 / 4d 7e bd f8, `err_o`=0.
- INV, `ColsPerCycle`=4: feed the FWD result above.
  - Required: original state back after 1 cycle.
  - Required: FWD followed by INV is the identity over 1000 random states for each `ColsPerCycle` value.
- Backpressure: hold `out_ready_i`=0 for 10 cycles in DONE.
  - Required: `data_o` stable, `in_ready_o`=0, and a second `in_valid_i` is not accepted until the cycle after the output handshake.
- Illegal op: `op_i`=2'b11, any data.
  - Required: `data_o`=0 and `err_o`=1 at normal latency.
  - Required: the next legal op produces `err_o`=0.
- `clear_i` asserted in the 2nd CALC cycle (`ColsPerCycle`=1).
  - Required: IDLE next cycle, `out_valid_o` never asserts, and the next state computes correctly.
- Asynchronous `rst_ni` pulse mid-CALC between clock edges.
  - Required: all outputs reach their reset values immediately.

Source files
------------

// File: rtl/aes_mix_columns_seq.sv
// aes_pkg: cipher operation encoding and the GF(2^8) helpers shared by the
// AES datapath blocks.
//
// aes_mix_columns_seq: sequential MixColumns / InvMixColumns engine for a full
// 4x4 AES state, transforming ColsPerCycle columns per clock in place.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   clear_i      synchronous abort; wipes state and returns to IDLE
//   op_i         CIPH_FWD / CIPH_INV, sampled on the input handshake only
//   in_valid_i   input state valid
//   in_ready_o   engine idle and able to accept a state
//   data_i       input state, [row][col]
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//   data_o       result, [row][col]; zero whenever no result is presented
//   err_o        latched op was illegal; meaningful while out_valid_o=1

package aes_pkg;

    typedef enum logic [1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;

    function automatic logic [7:0] aes_mul2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] aes_mul4(input logic [7:0] x);
        return aes_mul2(aes_mul2(x));
    endfunction

endpackage

module aes_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int ColsPerCycle = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  ciph_op_e              op_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [3:0][3:0][7:0]  data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [3:0][3:0][7:0]  data_o,
    output logic                  err_o
);

    localparam int NumSteps = 4 / ColsPerCycle;
    localparam int CntW     = (NumSteps > 1) ? $clog2(NumSteps) : 1;

    if (ColsPerCycle != 1 && ColsPerCycle != 2 && ColsPerCycle != 4) begin : gen_bad_cols
        $error("aes_mix_columns_seq: ColsPerCycle must be 1, 2 or 4");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]             fsm_q;
    logic [CntW-1:0]        cnt_q;
    logic                   inv_q;
    logic                   err_q;
    logic [3:0][3:0][7:0]   state_q;
    logic [3:0][3:0][7:0]   state_d;
    logic [1:0]             col_base;
    logic [1:0]             sel;
    logic [3:0][7:0]        col_in;
    logic [3:0][7:0]        col_out;
    logic                   last_step;
    logic                   accept;
    logic                   op_legal;

    // Inverse is done as a pre-multiply by {5,0,4,0} (rotated per row)
    // followed by the forward matrix, so both directions share one datapath.
    function automatic logic [3:0][7:0] mix_column(input logic [3:0][7:0] a,
                                                   input logic            inv);
        logic [3:0][7:0] x;
        logic [3:0][7:0] b;
        logic [7:0]      u;
        logic [7:0]      v;
        x = a;
        u = 8'h00;
        v = 8'h00;
        if (inv) begin
            u = aes_mul4(a[0] ^ a[2]);
            v = aes_mul4(a[1] ^ a[3]);
            x[0] = a[0] ^ u;
            x[1] = a[1] ^ v;
            x[2] = a[2] ^ u;
            x[3] = a[3] ^ v;
        end
        for (int i = 0; i < 4; i++) begin
            b[i] = aes_mul2(x[i]) ^ aes_mul2(x[(i + 1) % 4]) ^ x[(i + 1) % 4]
                 ^ x[(i + 2) % 4] ^ x[(i + 3) % 4];
        end
        return b;
    endfunction

    assign accept    = in_valid_i && (fsm_q == IDLE);
    assign op_legal  = (op_i == CIPH_FWD) || (op_i == CIPH_INV);
    assign col_base  = 2'(int'(cnt_q) * ColsPerCycle);
    assign last_step = (2'(col_base + 2'(ColsPerCycle - 1)) == 2'd3);

    // Only the columns selected by the counter are transformed this cycle.
    always_comb begin
        state_d = state_q;
        sel     = 2'd0;
        col_in  = '0;
        col_out = '0;
        for (int k = 0; k < ColsPerCycle; k++) begin
            sel = col_base + 2'(k);
            for (int r = 0; r < 4; r++) begin
                col_in[r] = state_q[r][sel];
            end
            col_out = mix_column(col_in, inv_q);
            for (int r = 0; r < 4; r++) begin
                state_d[r][sel] = col_out[r];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            inv_q <= 1'b0;
            err_q <= 1'b0;
        end else if (clear_i) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            inv_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid_i) begin
                        fsm_q <= CALC;
                        cnt_q <= '0;
                        inv_q <= (op_i == CIPH_INV);
                        err_q <= !op_legal;
                    end
                end
                CALC: begin
                    if (last_step) begin
                        fsm_q <= DONE;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        fsm_q <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    // State register is datapath only; outputs are gated by the FSM, so it
    // needs no reset. An illegal op loads zeros and leaves them untouched.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q <= '0;
        end else if (accept) begin
            state_q <= op_legal ? data_i : '0;
        end else if (fsm_q == CALC && !err_q) begin
            state_q <= state_d;
        end
    end

    assign in_ready_o  = (fsm_q == IDLE);
    assign out_valid_o = (fsm_q == DONE);
    assign data_o      = out_valid_o ? state_q : '0;
    assign err_o       = out_valid_o && err_q;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Self-checking bench for aes_mix_columns_seq: three instances (1, 2 and 4
// columns per cycle) share one stimulus stream and are compared every cycle
// against a transaction-level model built from the GF(2^8) matrix definition.
module tb_aes_mix_columns_seq;

    typedef logic [3:0][3:0][7:0] state_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [1:0]  op_raw;
    logic        in_valid;
    logic        out_ready;
    state_t      din;

    logic        in_ready  [3];
    logic        out_valid [3];
    logic        err       [3];
    state_t      dout      [3];

    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_mix_columns_seq #(.ColsPerCycle(1 << g)) dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .clear_i     (clear),
            .op_i        (aes_pkg::ciph_op_e'(op_raw)),
            .in_valid_i  (in_valid),
            .in_ready_o  (in_ready[g]),
            .data_i      (din),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready),
            .data_o      (dout[g]),
            .err_o       (err[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic state_t model(input state_t s, input logic [1:0] opv);
        logic [7:0] co [4];
        state_t     res;
        logic [7:0] acc;
        res = '0;
        if (opv == 2'b01)      co = '{8'h02, 8'h03, 8'h01, 8'h01};
        else if (opv == 2'b10) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else return res;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(co[(j - r + 4) % 4], s[j][c]);
                res[r][c] = acc;
            end
        end
        return res;
    endfunction

    int     lat  [3] = '{4, 2, 1};
    logic   busy [3] = '{1'b0, 1'b0, 1'b0};
    int     age  [3] = '{0, 0, 0};
    state_t exp_d[3];
    logic   exp_e[3] = '{1'b0, 1'b0, 1'b0};

    // Transaction timing: accepted -> result after lat cycles -> held until taken.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n || clear) begin
                busy[i] = 1'b0;
            end else if (busy[i] && age[i] >= lat[i]) begin
                if (out_ready) busy[i] = 1'b0;
            end else if (busy[i]) begin
                age[i] = age[i] + 1;
            end else if (in_valid) begin
                busy[i]  = 1'b1;
                age[i]   = 0;
                exp_d[i] = model(din, op_raw);
                exp_e[i] = !(op_raw == 2'b01 || op_raw == 2'b10);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic compare_all();
        logic   ev;
        state_t ed;
        logic   ee;
        for (int i = 0; i < 3; i++) begin
            ev = busy[i] && (age[i] >= lat[i]);
            ed = ev ? exp_d[i] : '0;
            ee = ev ? exp_e[i] : 1'b0;
            total++;
            if (out_valid[i] !== ev || in_ready[i] !== !busy[i]) begin
                bad++;
                $display("FAIL ctrl[%0d] t=%0t got valid=%b ready=%b want valid=%b ready=%b",
                         i, $time, out_valid[i], in_ready[i], ev, !busy[i]);
            end
            total++;
            if (dout[i] !== ed || err[i] !== ee) begin
                bad++;
                $display("FAIL data[%0d] t=%0t got %h err=%b want %h err=%b",
                         i, $time, dout[i], err[i], ed, ee);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    function automatic state_t rand_state();
        state_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = 8'($urandom);
        return s;
    endfunction

    task automatic check_state(input string name, input state_t got, input state_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic wait_all_valid();
        int n;
        n = 0;
        while (!(out_valid[0] && out_valid[1] && out_valid[2]) && n < 50) begin
            cyc();
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL timeout got valid=%b%b%b want 111",
                     out_valid[0], out_valid[1], out_valid[2]);
        end
    endtask

    state_t cap [3];

    task automatic run_txn(input logic [1:0] opv, input state_t d, input int hold);
        op_raw   = opv;
        din      = d;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        op_raw   = 2'($urandom);   // post-handshake changes must be ignored
        din      = rand_state();
        wait_all_valid();
        repeat (hold) cyc();
        for (int i = 0; i < 3; i++) cap[i] = dout[i];
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    logic [7:0] vin  [4][4] = '{'{8'hdb, 8'h13, 8'h53, 8'h45}, '{8'hf2, 8'h0a, 8'h22, 8'h5c},
                                '{8'h01, 8'h01, 8'h01, 8'h01}, '{8'h2d, 8'h26, 8'h31, 8'h4c}};
    logic [7:0] vout [4][4] = '{'{8'h8e, 8'h4d, 8'ha1, 8'hbc}, '{8'h9f, 8'hdc, 8'h58, 8'h9d},
                                '{8'h01, 8'h01, 8'h01, 8'h01}, '{8'h4d, 8'h7e, 8'hbd, 8'hf8}};

    initial begin
        #5_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        state_t s_in;
        state_t s_out;
        state_t s;
        state_t d2;

        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                s_in[r][c]  = vin[c][r];
                s_out[r][c] = vout[c][r];
            end

        clear = 1'b0; op_raw = 2'b01; in_valid = 1'b0; out_ready = 1'b0; din = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        // Pin the model to the known vector.
        check_state("model_fwd", model(s_in, 2'b01), s_out);
        check_state("model_inv", model(s_out, 2'b10), s_in);

        // Directed forward / inverse.
        run_txn(2'b01, s_in, 0);
        for (int i = 0; i < 3; i++) check_state("vec_fwd", cap[i], s_out);
        run_txn(2'b10, s_out, 0);
        for (int i = 0; i < 3; i++) check_state("vec_inv", cap[i], s_in);

        // Backpressure with a second request pending across the handshake.
        run_txn(2'b01, rand_state(), 0);
        op_raw   = 2'b01;
        din      = s_in;
        in_valid = 1'b1;
        cyc();
        wait_all_valid();
        d2 = rand_state();
        op_raw   = 2'b10;
        din      = d2;
        in_valid = 1'b1;
        repeat (10) cyc();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        wait_all_valid();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Illegal op, then a legal one.
        run_txn(2'b11, rand_state(), 2);
        for (int i = 0; i < 3; i++) check_state("illegal_data", cap[i], '0);
        run_txn(2'b00, rand_state(), 0);
        run_txn(2'b01, s_in, 0);

        // Clear in the second CALC cycle of the one-column instance.
        op_raw = 2'b01; din = rand_state(); in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        repeat (6) cyc();
        run_txn(2'b10, s_out, 0);

        // Asynchronous reset pulse mid-CALC, between clock edges.
        op_raw = 2'b01; din = rand_state(); in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || dout[i] !== '0 || err[i] !== 1'b0) begin
                bad++;
                $display("FAIL async_rst[%0d] got ready=%b valid=%b data=%h err=%b want 1 0 0 0",
                         i, in_ready[i], out_valid[i], dout[i], err[i]);
            end
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cyc();
        run_txn(2'b01, s_in, 1);

        // Forward then inverse is the identity.
        for (int n = 0; n < 1000; n++) begin
            s = rand_state();
            run_txn(2'b01, s, 0);
            run_txn(2'b10, model(s, 2'b01), int'($urandom_range(0, 2)));
            for (int i = 0; i < 3; i++) check_state("identity", cap[i], s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
